// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: the mdu_mod operation
// codes (also decoded by the control unit), the FSM state type and a small
// magnitude helper used by the divider.
package mdu_pkg;

    localparam int DATA_W = 32;

    // mdu_mod operation codes
    localparam logic [2:0] MDU_MUL_SIGNED   = 3'b000;
    localparam logic [2:0] MDU_MUL_UNSIGNED = 3'b001;
    localparam logic [2:0] MDU_DIV_SIGNED   = 3'b010;
    localparam logic [2:0] MDU_DIV_UNSIGNED = 3'b011;
    localparam logic [2:0] MDU_MOVETO_HI    = 3'b100;
    localparam logic [2:0] MDU_MOVETO_LO    = 3'b101;
    localparam logic [2:0] MDU_RESERVED     = 3'b110;
    localparam logic [2:0] MDU_NONE         = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    // Magnitude of a value that is two's complement when is_signed is set.
    // The most negative value maps to itself, which is its correct unsigned
    // magnitude.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                  input logic              is_signed);
        return (is_signed && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
    endfunction

endpackage

// File: rtl/mdu_div32.sv
// Combinational 32-bit divider: signed or unsigned quotient and remainder.
// Signed results truncate toward zero; the remainder follows the dividend's
// sign. div_zero flags a zero divisor so the caller can skip the write-back.
module mdu_div32
    import mdu_pkg::*;
(
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic        q_neg;
    logic        r_neg;

    // Divide magnitudes, then restore the signs of quotient and remainder
    always_comb begin
        mag_a     = abs_val(dividend, is_signed);
        mag_b     = abs_val(divisor, is_signed);
        div_zero  = (divisor == 32'd0);
        safe_b    = div_zero ? 32'd1 : mag_b;
        mag_q     = mag_a / safe_b;
        mag_r     = mag_a % safe_b;
        q_neg     = is_signed && (dividend[31] ^ divisor[31]);
        r_neg     = is_signed && dividend[31];
        quotient  = q_neg ? (~mag_q + 32'd1) : mag_q;
        remainder = r_neg ? (~mag_r + 32'd1) : mag_r;
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. A launched operation holds busy
// for a fixed number of cycles and writes HI/LO on the edge busy falls.
// mthi/mtlo write immediately when the unit is idle.
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_mod,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_N) + 1;

    mdu_state_t state;
    mdu_state_t state_next;

    logic [CNT_W-1:0] cnt;
    logic             launch;
    logic             result_we;
    logic             mthi_we;
    logic             mtlo_we;

    // Operands latched at launch; op_sel_p0[1] = divide, op_sel_p0[0] = unsigned
    logic [31:0] op_a_p0;
    logic [31:0] op_b_p0;
    logic [1:0]  op_sel_p0;

    logic        mul_sext;
    logic [63:0] mul_prod;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_zero;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic: launch from IDLE, return when the countdown expires
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start && !mdu_mod[2]) state_next = ST_RUN;
            ST_RUN:  if (cnt == '0)            state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    // Output decode: busy and the register write strobes
    always_comb begin
        busy      = (state == ST_RUN);
        launch    = (state == ST_IDLE) && start && !mdu_mod[2];
        result_we = (state == ST_RUN) && (cnt == '0);
        mthi_we   = (state == ST_IDLE) && (mdu_mod == MDU_MOVETO_HI);
        mtlo_we   = (state == ST_IDLE) && (mdu_mod == MDU_MOVETO_LO);
    end

    // Countdown: loaded with N-1 at launch, decremented while running
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (launch)
            cnt <= mdu_mod[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
        else if (state == ST_RUN && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    // ---- stage p0: operand capture at launch ----
    // Operand latch so later input changes cannot disturb the running operation
    always_ff @(posedge clk) begin
        if (launch) begin
            op_a_p0   <= src_a;
            op_b_p0   <= src_b;
            op_sel_p0 <= mdu_mod[1:0];
        end
    end

    // Single 64-bit multiplier; sign- or zero-extension selects mult vs multu
    always_comb begin
        mul_sext = !op_sel_p0[0];
        mul_prod = {{32{mul_sext & op_a_p0[31]}}, op_a_p0} *
                   {{32{mul_sext & op_b_p0[31]}}, op_b_p0};
    end

    mdu_div32 u_div (
        .dividend  (op_a_p0),
        .divisor   (op_b_p0),
        .is_signed (!op_sel_p0[0]),
        .quotient  (div_q),
        .remainder (div_r),
        .div_zero  (div_zero)
    );

    // ---- result write-back ----
    // HI/LO update: result on the final busy edge, mthi/mtlo only when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (result_we) begin
            if (!op_sel_p0[1]) begin
                hi <= mul_prod[63:32];
                lo <= mul_prod[31:0];
            end else if (!div_zero) begin
                hi <= div_r;
                lo <= div_q;
            end
        end else begin
            if (mthi_we) hi <= src_a;
            if (mtlo_we) lo <= src_a;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Testbench for mdu: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model built from plain arithmetic.
module tb_mdu;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_mod;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_left;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    bit          p_wr;

    mdu #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdu_mod (mdu_mod),
        .src_a   (src_a),
        .src_b   (src_b),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left = 0;
        m_hi   = '0;
        m_lo   = '0;
        p_wr   = 1'b0;
    endtask

    // Effect of one rising edge with the given inputs
    task automatic model_edge(input logic s, input logic [2:0] m,
                              input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, pu;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (s && m < 3'd4) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            ua = longint'(a);
            ub = longint'(b);
            p_wr = 1'b1;
            case (m)
                3'd0: begin q = sa * sb; {p_hi, p_lo} = q; m_left = MUL_N; end
                3'd1: begin pu = ua * ub; {p_hi, p_lo} = pu; m_left = MUL_N; end
                3'd2: begin
                    m_left = DIV_N;
                    if (b == 0) p_wr = 1'b0;
                    else begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; end
                end
                default: begin
                    m_left = DIV_N;
                    if (b == 0) p_wr = 1'b0;
                    else begin pu = ua / ub; p_lo = pu[31:0]; pu = ua % ub; p_hi = pu[31:0]; end
                end
            endcase
        end else if (m == 3'd4) begin
            m_hi = a;
        end else if (m == 3'd5) begin
            m_lo = a;
        end
    endtask

    // Drive at the falling edge, clock once, compare on the next falling edge
    task automatic step(input logic s, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] b);
        start   = s;
        mdu_mod = m;
        src_a   = a;
        src_b   = b;
        @(posedge clk);
        model_edge(s, m, a, b);
        @(negedge clk);
        chk("busy", busy, (m_left > 0));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    // Count busy cycles after a launch while throwing random traffic at the unit
    task automatic run_lat(input string tag, input int expn);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
        end
        chk(tag, n, expn);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        mdu_mod = 3'b111;
        src_a   = '0;
        src_b   = '0;
        model_reset();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;

        // mult -2 * 3
        step(1, 3'b000, 32'hFFFF_FFFE, 32'd3);
        run_lat("mult_lat", MUL_N);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // multu 0xFFFFFFFF * 2 (HI/LO hold is checked every busy cycle by step)
        step(1, 3'b001, 32'hFFFF_FFFF, 32'd2);
        run_lat("multu_lat", MUL_N);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // div -7 / 2
        step(1, 3'b010, 32'hFFFF_FFF9, 32'd2);
        run_lat("div_lat", DIV_N);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);

        // divu 7 / 0 leaves HI/LO alone
        step(1, 3'b011, 32'd7, 32'd0);
        run_lat("divz_lat", DIV_N);
        chk("divz_hi", hi, 32'hFFFF_FFFF);
        chk("divz_lo", lo, 32'hFFFF_FFFD);

        // most negative / -1
        step(1, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        run_lat("ovf_lat", DIV_N);
        chk("ovf_hi", hi, 32'h0000_0000);
        chk("ovf_lo", lo, 32'h8000_0000);

        // mthi then mtlo, start low, no busy
        step(0, 3'b100, 32'h1234_5678, 32'd0);
        chk("mthi_hi", hi, 32'h1234_5678);
        step(0, 3'b101, 32'h9ABC_DEF0, 32'd0);
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);
        chk("mt_busy", busy, 0);

        // start with a no-op code must not assert busy
        step(1, 3'b110, 32'd1, 32'd1);
        chk("rsv_busy", busy, 0);

        // mult with divu and mthi arriving while busy
        step(1, 3'b000, 32'd6, 32'd7);
        step(1, 3'b011, 32'd100, 32'd3);
        step(0, 3'b100, 32'hDEAD_BEEF, 32'd0);
        run_lat("ovl_lat", MUL_N - 2);
        chk("ovl_hi", hi, 32'd0);
        chk("ovl_lo", lo, 32'd42);

        // reset in the third busy cycle of a div
        step(0, 3'b100, 32'hAAAA_AAAA, 32'd0);
        step(1, 3'b010, 32'd100, 32'd7);
        step(0, 3'b111, 32'd0, 32'd0);
        step(0, 3'b111, 32'd0, 32'd0);
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1, 3'b001, 32'd9, 32'd9);
        run_lat("post_rst_lat", MUL_N);
        chk("post_rst_lo", lo, 32'd81);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), pick(), pick());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
